// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-client DataMemory arbiter.
package mem_arbiter_pkg;

    localparam int LINE_SIZE_DEF  = 16;
    localparam int ADDR_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUSY_RD = 2'b01,
        ARB_BUSY_WR = 2'b10
    } arb_state_t;

    // A client competes for memory only when it actually wants a read or a write.
    function automatic logic is_eligible(input logic req_valid, input logic rd, input logic wr);
        return req_valid && (rd || wr);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational two-way round-robin pick: on a tie the client that was not granted last wins.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide DataMemory between the I-cache (client 0) and the D-cache (client 1),
// holding each grant for a whole fill or write-back and steering the response to its owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_SIZE  = LINE_SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     c0_req_valid,
    input  logic [ADDR_WIDTH-1:0]    c0_addr,
    input  logic                     c0_mem_read,
    input  logic                     c0_mem_write,
    input  logic [LINE_SIZE*8-1:0]   c0_din,
    output logic                     c0_ready,
    output logic                     c0_output_valid,
    output logic [LINE_SIZE*8-1:0]   c0_dout,
    output logic                     c0_done,
    input  logic                     c1_req_valid,
    input  logic [ADDR_WIDTH-1:0]    c1_addr,
    input  logic                     c1_mem_read,
    input  logic                     c1_mem_write,
    input  logic [LINE_SIZE*8-1:0]   c1_din,
    output logic                     c1_ready,
    output logic                     c1_output_valid,
    output logic [LINE_SIZE*8-1:0]   c1_dout,
    output logic                     c1_done,
    output logic                     mem_is_input_valid,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [LINE_SIZE*8-1:0]   mem_din,
    input  logic                     mem_is_output_valid,
    input  logic [LINE_SIZE*8-1:0]   mem_dout,
    input  logic                     mem_ready
);

    arb_state_t state, next_state;
    logic       owner;
    logic       last_grant;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       sel;
    logic [31:0] grant_cnt [2];
    logic [31:0] conflict_cnt;

    assign eligible[0] = is_eligible(c0_req_valid, c0_mem_read, c0_mem_write);
    assign eligible[1] = is_eligible(c1_req_valid, c1_mem_read, c1_mem_write);

    rr_arbiter2 u_rr (
        .req        (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ARB_IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            grant_cnt[0] <= '0;
            grant_cnt[1] <= '0;
            conflict_cnt <= '0;
        end else begin
            state <= next_state;
            if (c0_ready || c1_ready) begin
                owner      <= c1_ready;
                last_grant <= c1_ready;
            end
            if (c0_ready)
                grant_cnt[0] <= grant_cnt[0] + 32'd1;
            if (c1_ready)
                grant_cnt[1] <= grant_cnt[1] + 32'd1;
            if (state == ARB_IDLE && eligible == 2'b11)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    // Outputs are forced quiet while reset is held, even though the FSM already sits in IDLE.
    always_comb begin
        next_state         = state;
        sel                = 1'b0;
        c0_ready           = 1'b0;
        c1_ready           = 1'b0;
        c0_output_valid    = 1'b0;
        c1_output_valid    = 1'b0;
        c0_dout            = '0;
        c1_dout            = '0;
        c0_done            = 1'b0;
        c1_done            = 1'b0;
        mem_is_input_valid = 1'b0;
        mem_addr           = '0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_din            = '0;
        if (!reset) begin
            case (state)
                ARB_IDLE: begin
                    if (mem_ready && grant != 2'b00) begin
                        sel                = grant[1];
                        c0_ready           = grant[0];
                        c1_ready           = grant[1];
                        mem_is_input_valid = 1'b1;
                        mem_addr           = sel ? c1_addr : c0_addr;
                        mem_din            = sel ? c1_din  : c0_din;
                        // A request flagged both read and write is a write-back.
                        mem_write          = sel ? c1_mem_write : c0_mem_write;
                        mem_read           = !mem_write && (sel ? c1_mem_read : c0_mem_read);
                        next_state         = mem_write ? ARB_BUSY_WR : ARB_BUSY_RD;
                    end
                end
                ARB_BUSY_RD: begin
                    if (mem_is_output_valid) begin
                        if (owner) begin
                            c1_output_valid = 1'b1;
                            c1_done         = 1'b1;
                            c1_dout         = mem_dout;
                        end else begin
                            c0_output_valid = 1'b1;
                            c0_done         = 1'b1;
                            c0_dout         = mem_dout;
                        end
                        next_state = ARB_IDLE;
                    end
                end
                ARB_BUSY_WR: begin
                    if (mem_ready) begin
                        c0_done    = !owner;
                        c1_done    = owner;
                        next_state = ARB_IDLE;
                    end
                end
                default: next_state = ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_mem_arbiter;

    localparam int LS = 16;
    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          c0_req_valid, c0_mem_read, c0_mem_write;
    logic [AW-1:0] c0_addr;
    logic [LS*8-1:0] c0_din;
    logic          c0_ready, c0_output_valid, c0_done;
    logic [LS*8-1:0] c0_dout;
    logic          c1_req_valid, c1_mem_read, c1_mem_write;
    logic [AW-1:0] c1_addr;
    logic [LS*8-1:0] c1_din;
    logic          c1_ready, c1_output_valid, c1_done;
    logic [LS*8-1:0] c1_dout;
    logic          mem_is_input_valid, mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [LS*8-1:0] mem_din;
    logic          mem_is_output_valid, mem_ready;
    logic [LS*8-1:0] mem_dout;

    int tests_run;
    int tests_failed;

    mem_arbiter #(.LINE_SIZE(LS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_addr(c0_addr), .c0_mem_read(c0_mem_read),
        .c0_mem_write(c0_mem_write), .c0_din(c0_din), .c0_ready(c0_ready),
        .c0_output_valid(c0_output_valid), .c0_dout(c0_dout), .c0_done(c0_done),
        .c1_req_valid(c1_req_valid), .c1_addr(c1_addr), .c1_mem_read(c1_mem_read),
        .c1_mem_write(c1_mem_write), .c1_din(c1_din), .c1_ready(c1_ready),
        .c1_output_valid(c1_output_valid), .c1_dout(c1_dout), .c1_done(c1_done),
        .mem_is_input_valid(mem_is_input_valid), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_din(mem_din), .mem_is_output_valid(mem_is_output_valid),
        .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_phase();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        c0_req_valid = 0; c0_mem_read = 0; c0_mem_write = 0; c0_addr = '0; c0_din = '0;
        c1_req_valid = 0; c1_mem_read = 0; c1_mem_write = 0; c1_addr = '0; c1_din = '0;
        mem_is_output_valid = 0; mem_dout = '0; mem_ready = 0;
    endtask

    task automatic do_reset();
        next_phase();
        idle_inputs();
        reset = 1;
        next_phase();
        reset = 0;
    endtask

    localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] D2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] W1 = 128'hcafe_f00d_cafe_f00d_cafe_f00d_cafe_f00d;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        idle_inputs();
        reset = 1;
        mem_ready = 1;
        c0_req_valid = 1; c0_mem_read = 1;
        repeat (2) @(posedge clk);
        #1;
        // Outputs held quiet by reset even with an eligible request and mem_ready.
        check("rst_c0_ready", c0_ready, 0);
        check("rst_mem_valid", mem_is_input_valid, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_state", dut.state, 2'b00);
        check("rst_last_grant", dut.last_grant, 1);
        check("rst_conflict", dut.conflict_cnt, 0);
        next_phase();
        idle_inputs();
        reset = 0;

        // Test 1: c0 read alone.
        next_phase();
        c0_req_valid = 1; c0_mem_read = 1; c0_addr = 32'h10; mem_ready = 1;
        #1;
        check("t1_c0_ready", c0_ready, 1);
        check("t1_c1_ready", c1_ready, 0);
        check("t1_mem_valid", mem_is_input_valid, 1);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_read", mem_read, 1);
        check("t1_mem_write", mem_write, 0);
        next_phase();
        c0_req_valid = 0; c0_mem_read = 0;
        #1;
        check("t1_state_rd", dut.state, 2'b01);
        check("t1_mem_idle", mem_is_input_valid, 0);
        check("t1_no_done", c0_done, 0);
        next_phase();
        mem_is_output_valid = 1; mem_dout = D1;
        #1;
        check("t1_ovalid", c0_output_valid, 1);
        check("t1_dout", c0_dout, D1);
        check("t1_done", c0_done, 1);
        check("t1_c1_dout", c1_dout, 0);
        check("t1_c1_done", c1_done, 0);
        next_phase();
        mem_is_output_valid = 0; mem_dout = '0;
        #1;
        check("t1_state_idle", dut.state, 2'b00);
        check("t1_done_pulse", c0_done, 0);
        check("t1_gcnt0", dut.grant_cnt[0], 1);

        // Test 2: simultaneous reads after reset, then a repeated tie.
        do_reset();
        c0_req_valid = 1; c0_mem_read = 1; c0_addr = 32'h100;
        c1_req_valid = 1; c1_mem_read = 1; c1_addr = 32'h200;
        mem_ready = 1;
        #1;
        check("t2_tie_c0_ready", c0_ready, 1);
        check("t2_tie_c1_ready", c1_ready, 0);
        check("t2_tie_addr", mem_addr, 32'h100);
        next_phase();
        c0_req_valid = 0; c0_mem_read = 0;
        #1;
        check("t2_busy_c1_ready", c1_ready, 0);
        check("t2_conflict1", dut.conflict_cnt, 1);
        next_phase();
        mem_is_output_valid = 1; mem_dout = D2;
        #1;
        check("t2_c0_done", c0_done, 1);
        check("t2_c0_dout", c0_dout, D2);
        check("t2_c1_ready_in_done", c1_ready, 0);
        next_phase();
        mem_is_output_valid = 0; mem_dout = '0;
        #1;
        check("t2_c1_ready", c1_ready, 1);
        check("t2_c1_addr", mem_addr, 32'h200);
        next_phase();
        c1_req_valid = 0; c1_mem_read = 0;
        next_phase();
        mem_is_output_valid = 1; mem_dout = D3;
        #1;
        check("t2_c1_ovalid", c1_output_valid, 1);
        check("t2_c1_dout", c1_dout, D3);
        check("t2_c0_dout_gated", c0_dout, 0);
        check("t2_c0_ovalid_gated", c0_output_valid, 0);
        next_phase();
        mem_is_output_valid = 0; mem_dout = '0;
        c0_req_valid = 1; c0_mem_read = 1; c0_addr = 32'h300;
        c1_req_valid = 1; c1_mem_read = 1; c1_addr = 32'h400;
        #1;
        check("t2_retie_c0_ready", c0_ready, 1);
        check("t2_retie_c1_ready", c1_ready, 0);
        next_phase();
        idle_inputs(); mem_ready = 1;
        #1;
        check("t2_conflict2", dut.conflict_cnt, 2);
        check("t2_gcnt1", dut.grant_cnt[1], 1);
        next_phase();
        mem_is_output_valid = 1;
        next_phase();
        mem_is_output_valid = 0;

        // Test 3: c1 write-back with a stalled memory and c0 waiting.
        next_phase();
        c1_req_valid = 1; c1_mem_write = 1; c1_addr = 32'h20; c1_din = W1;
        #1;
        check("t3_c1_ready", c1_ready, 1);
        check("t3_mem_write", mem_write, 1);
        check("t3_mem_read", mem_read, 0);
        check("t3_mem_din", mem_din, W1);
        check("t3_mem_addr", mem_addr, 32'h20);
        next_phase();
        c1_req_valid = 0; c1_mem_write = 0; c1_din = '0;
        c0_req_valid = 1; c0_mem_read = 1; c0_addr = 32'h30;
        mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            mem_is_output_valid = (i == 2);
            #1;
            check("t3_stall_c1_done", c1_done, 0);
            check("t3_stall_c0_ready", c0_ready, 0);
            check("t3_spurious_ovalid", c1_output_valid | c0_output_valid, 0);
            next_phase();
        end
        mem_is_output_valid = 0;
        mem_ready = 1;
        #1;
        check("t3_c1_done", c1_done, 1);
        check("t3_c0_wait", c0_ready, 0);
        check("t3_no_mem_req", mem_is_input_valid, 0);
        next_phase();
        #1;
        check("t3_c0_granted", c0_ready, 1);
        check("t3_c0_addr", mem_addr, 32'h30);
        next_phase();
        c0_req_valid = 0; c0_mem_read = 0;
        mem_is_output_valid = 1;
        next_phase();
        mem_is_output_valid = 0;

        // Test 4: read and write both set is a write.
        next_phase();
        c0_req_valid = 1; c0_mem_read = 1; c0_mem_write = 1; c0_addr = 32'h40;
        #1;
        check("t4_mem_write", mem_write, 1);
        check("t4_mem_read", mem_read, 0);
        next_phase();
        c0_req_valid = 0; c0_mem_read = 0; c0_mem_write = 0;
        #1;
        check("t4_state_wr", dut.state, 2'b10);
        check("t4_c0_done", c0_done, 1);
        next_phase();

        // Test 5: reset while a read is in flight drops the response.
        c0_req_valid = 1; c0_mem_read = 1; c0_addr = 32'h50;
        next_phase();
        c0_req_valid = 0; c0_mem_read = 0;
        #1;
        check("t5_state_rd", dut.state, 2'b01);
        next_phase();
        reset = 1;
        #1;
        check("t5_rst_state", dut.state, 2'b00);
        check("t5_rst_last", dut.last_grant, 1);
        next_phase();
        reset = 0;
        mem_ready = 0;
        mem_is_output_valid = 1; mem_dout = D1;
        #1;
        check("t5_no_ovalid", c0_output_valid, 0);
        check("t5_no_done", c0_done, 0);
        check("t5_dout_zero", c0_dout, 0);
        check("t5_gcnt_cleared", dut.grant_cnt[0], 0);
        next_phase();
        mem_is_output_valid = 0; mem_dout = '0;

        // Test 6: both requesting while memory is not ready.
        c0_req_valid = 1; c0_mem_read = 1; c0_addr = 32'h60;
        c1_req_valid = 1; c1_mem_read = 1; c1_addr = 32'h70;
        #1;
        check("t6_c0_ready", c0_ready, 0);
        check("t6_c1_ready", c1_ready, 0);
        check("t6_mem_valid", mem_is_input_valid, 0);
        check("t6_mem_addr", mem_addr, 0);
        next_phase();
        #1;
        check("t6_conflict1", dut.conflict_cnt, 1);
        next_phase();
        #1;
        check("t6_conflict2", dut.conflict_cnt, 2);
        mem_ready = 1;
        #1;
        check("t6_c0_granted", c0_ready, 1);
        next_phase();
        idle_inputs();
        next_phase();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
